// File: rtl/remote_comm_if.sv
// remote_comm_if: host-side command/response bundle for remote_comm
//   master (host/bench): drives snd_cmd, cmd[15:0], clr_resp_rdy, RX
//   slave  (remote_comm): drives cmd_snt, busy, TX, resp_rdy, resp[7:0]
//   resp_to exists only when REMOTE_COMM_TIMEOUT_EN is defined
interface remote_comm_if;
  logic        snd_cmd;
  logic [15:0] cmd;
  logic        cmd_snt;
  logic        TX;
  logic        RX;
  logic        clr_resp_rdy;
  logic        resp_rdy;
  logic [7:0]  resp;
  logic        busy;
`ifdef REMOTE_COMM_TIMEOUT_EN
  logic        resp_to;
  modport master(output snd_cmd, cmd, RX, clr_resp_rdy,
                 input cmd_snt, TX, resp_rdy, resp, busy, resp_to);
  modport slave(input snd_cmd, cmd, RX, clr_resp_rdy,
                output cmd_snt, TX, resp_rdy, resp, busy, resp_to);
`else
  modport master(output snd_cmd, cmd, RX, clr_resp_rdy,
                 input cmd_snt, TX, resp_rdy, resp, busy);
  modport slave(input snd_cmd, cmd, RX, clr_resp_rdy,
                output cmd_snt, TX, resp_rdy, resp, busy);
`endif
endinterface

// File: rtl/remote_comm.sv
// remote_comm: host-side UART command source (2-byte 8N1 TX) and 1-byte response receiver
//   clk, rst_n : 50 MHz clock, asynchronous active-low reset
//   bus        : remote_comm_if.slave (snd_cmd/cmd in, cmd_snt/busy/TX out,
//                RX/clr_resp_rdy in, resp_rdy/resp out)
//   Optional REMOTE_COMM_TIMEOUT_EN adds bus.resp_to, set when no valid response
//   arrives within TO_CYCLES clocks of cmd_snt.
module remote_comm #(
  parameter int BAUD_DIV  = 5208,
  parameter int TO_CYCLES = 25000000
) (
  input logic clk,
  input logic rst_n,
  remote_comm_if.slave bus
);
  typedef enum logic [1:0] {TX_IDLE, TX_HIGH, TX_LOW, TX_DONE} tx_state_e;
  typedef enum logic {RX_IDLE, RX_RECV} rx_state_e;
  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [15:0] BAUD_HALF = 16'(BAUD_DIV / 2 - 1);
  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] hold_q, hold_d, tbaud_q, tbaud_d;
  logic [3:0]  tbit_q, tbit_d;
  logic [7:0]  tx_byte;
  logic        accept, tx_bit_end, sending, cmd_snt;
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rbaud_q, rbaud_d;
  logic [3:0]  rbit_q, rbit_d;
  logic [7:0]  rshift_q, rshift_d, resp_q, resp_d;
  logic        resp_rdy_q, resp_rdy_d, rx_valid;
  logic        rx_s1_q, rx_s2_q, rx_s3_q;
  assign sending    = tx_state_q == TX_HIGH || tx_state_q == TX_LOW;
  assign tx_bit_end = tbaud_q == BAUD_LAST;
  assign tx_byte    = tx_state_q == TX_HIGH ? hold_q[15:8] : hold_q[7:0];
  assign cmd_snt    = tx_state_q == TX_DONE;
  // TX is decoded from state so it is high combinationally out of reset
  assign bus.TX       = !sending ? 1'b1 : tbit_q == 4'd0 ? 1'b0 : tbit_q == 4'd9 ? 1'b1
                        : tx_byte[3'(tbit_q - 4'd1)];
  assign bus.busy     = sending;
  assign bus.cmd_snt  = cmd_snt;
  assign bus.resp     = resp_q;
  assign bus.resp_rdy = resp_rdy_q;
  always_comb begin
    tx_state_d = tx_state_q;
    hold_d     = hold_q;
    tbaud_d    = tbaud_q;
    tbit_d     = tbit_q;
    accept     = 1'b0;
    case (tx_state_q)
      TX_IDLE: if (bus.snd_cmd) begin
        accept     = 1'b1;
        hold_d     = bus.cmd;
        tbaud_d    = '0;
        tbit_d     = '0;
        tx_state_d = TX_HIGH;
      end
      TX_HIGH, TX_LOW: begin
        tbaud_d = tx_bit_end ? '0 : tbaud_q + 16'd1;
        if (tx_bit_end) begin
          tbit_d = tbit_q == 4'd9 ? 4'd0 : tbit_q + 4'd1;
          // low frame follows the high stop bit with no idle gap
          if (tbit_q == 4'd9) tx_state_d = tx_state_q == TX_HIGH ? TX_LOW : TX_DONE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end
  always_comb begin
    rx_state_d = rx_state_q;
    rbaud_d    = rbaud_q;
    rbit_d     = rbit_q;
    rshift_d   = rshift_q;
    rx_valid   = 1'b0;
    case (rx_state_q)
      RX_IDLE: if (rx_s3_q && !rx_s2_q) begin
        rx_state_d = RX_RECV;
        rbaud_d    = BAUD_HALF;
        rbit_d     = '0;
      end
      default: if (rbaud_q == '0) begin
        rbaud_d = BAUD_LAST;
        rbit_d  = rbit_q + 4'd1;
        if (rbit_q == 4'd0 && rx_s2_q) rx_state_d = RX_IDLE;
        else if (rbit_q == 4'd9) begin
          rx_state_d = RX_IDLE;
          rx_valid   = rx_s2_q;
        end
        // the start bit also enters here but is pushed out by the 8 data bits
        else rshift_d = {rx_s2_q, rshift_q[7:1]};
      end else rbaud_d = rbaud_q - 16'd1;
    endcase
    resp_d     = rx_valid ? rshift_q : resp_q;
    resp_rdy_d = rx_valid | (resp_rdy_q & ~bus.clr_resp_rdy & ~accept);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      hold_q     <= '0;
      tbaud_q    <= '0;
      tbit_q     <= '0;
      rx_state_q <= RX_IDLE;
      rbaud_q    <= '0;
      rbit_q     <= '0;
      rshift_q   <= '0;
      resp_q     <= '0;
      resp_rdy_q <= 1'b0;
      {rx_s1_q, rx_s2_q, rx_s3_q} <= 3'b111;
    end else begin
      tx_state_q <= tx_state_d;
      hold_q     <= hold_d;
      tbaud_q    <= tbaud_d;
      tbit_q     <= tbit_d;
      rx_state_q <= rx_state_d;
      rbaud_q    <= rbaud_d;
      rbit_q     <= rbit_d;
      rshift_q   <= rshift_d;
      resp_q     <= resp_d;
      resp_rdy_q <= resp_rdy_d;
      {rx_s1_q, rx_s2_q, rx_s3_q} <= {bus.RX, rx_s1_q, rx_s2_q};
    end
`ifdef REMOTE_COMM_TIMEOUT_EN
  localparam logic [24:0] TO_LAST = 25'(TO_CYCLES - 1);
  logic [24:0] to_cnt_q, to_cnt_d;
  logic        armed_q, armed_d, resp_to_q, resp_to_d;
  assign bus.resp_to = resp_to_q;
  always_comb begin
    to_cnt_d  = to_cnt_q + 25'd1;
    armed_d   = armed_q;
    resp_to_d = resp_to_q & ~bus.clr_resp_rdy & ~accept;
    if (cmd_snt) begin
      to_cnt_d = '0;
      armed_d  = 1'b1;
    end else if (armed_q && rx_valid) armed_d = 1'b0;
    else if (armed_q && to_cnt_d == TO_LAST) begin
      resp_to_d = 1'b1;
      armed_d   = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      to_cnt_q  <= '0;
      armed_q   <= 1'b0;
      resp_to_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      armed_q   <= armed_d;
      resp_to_q <= resp_to_d;
    end
`endif
endmodule

// File: tb/tb_remote_comm.sv
// tb_remote_comm: scoreboard bench for remote_comm (BAUD_DIV=16, TO_CYCLES=2000)
module tb_remote_comm;
  localparam int B = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  remote_comm_if bus();
  remote_comm #(.BAUD_DIV(B), .TO_CYCLES(2000)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rst_gen = 0;
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];
  int exp_snt[$];
  logic prev_rdy = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tx_decode();
    int g;
    logic st;
    logic [7:0] d;
    g = rst_gen;
    repeat (B / 2) @(negedge clk);
    st = bus.TX;
    for (int i = 0; i < 8; i++) begin
      repeat (B) @(negedge clk);
      d[i] = bus.TX;
    end
    repeat (B) @(negedge clk);
    if (g == rst_gen) begin
      check("tx_start_bit", {31'd0, st}, 0);
      check("tx_stop_bit", {31'd0, bus.TX}, 1);
      if (exp_tx.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected_byte: got %0h expected none", d);
      end else check("tx_byte", {24'd0, d}, {24'd0, exp_tx.pop_front()});
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (rst_n && bus.TX === 1'b0) tx_decode();
  end
  initial forever begin
    @(negedge clk);
    if (bus.cmd_snt === 1'b1) begin
      check("busy_at_cmd_snt", {31'd0, bus.busy}, 0);
      if (exp_snt.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cmd_snt_unexpected: got cycle %0d expected none", cyc);
      end else check("cmd_snt_cycle", cyc, exp_snt.pop_front());
    end
  end
  initial forever begin
    @(negedge clk);
    if (bus.resp_rdy === 1'b1 && !prev_rdy) begin
      if (exp_rx.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected: got %0h expected none", bus.resp);
      end else check("resp_byte", {24'd0, bus.resp}, {24'd0, exp_rx.pop_front()});
    end
    prev_rdy = bus.resp_rdy;
  end
  task automatic send_cmd(logic [15:0] c);
    @(negedge clk);
    bus.cmd = c;
    bus.snd_cmd = 1'b1;
    exp_snt.push_back(cyc + 20 * B + 1);
    exp_tx.push_back(c[15:8]);
    exp_tx.push_back(c[7:0]);
    @(negedge clk);
    bus.snd_cmd = 1'b0;
  endtask
  task automatic rx_frame(logic [7:0] d, logic stop);
    if (stop) exp_rx.push_back(d);
    @(negedge clk);
    bus.RX = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.RX = d[i];
      repeat (B) @(negedge clk);
    end
    bus.RX = stop;
    repeat (B) @(negedge clk);
    bus.RX = 1'b1;
  endtask
  task automatic wait_snt_drained();
    for (int i = 0; i < 20 * B + 50 && exp_snt.size() != 0; i++) @(negedge clk);
    check("cmd_snt_seen", exp_snt.size(), 0);
    repeat (B) @(negedge clk);
  endtask
  initial begin
    int n_tx, n_busy, n_rdy, n_resp, k;
    bus.snd_cmd = 1'b0;
    bus.cmd = '0;
    bus.RX = 1'b1;
    bus.clr_resp_rdy = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n_tx = 0; n_busy = 0; n_rdy = 0; n_resp = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      n_tx += int'(bus.TX !== 1'b1);
      n_busy += int'(bus.busy !== 1'b0);
      n_rdy += int'(bus.resp_rdy !== 1'b0);
      n_resp += int'(bus.resp !== 8'h00);
    end
    check("idle_tx_not_high", n_tx, 0);
    check("idle_busy", n_busy, 0);
    check("idle_resp_rdy", n_rdy, 0);
    check("idle_resp_nonzero", n_resp, 0);
    send_cmd(16'h2A51);
    check("busy_after_accept", {31'd0, bus.busy}, 1);
    repeat (48) @(negedge clk);
    bus.cmd = 16'hFFFF;
    bus.snd_cmd = 1'b1;
    @(negedge clk);
    bus.snd_cmd = 1'b0;
    wait_snt_drained();
    check("tx_bytes_drained", exp_tx.size(), 0);
    rx_frame(8'hA5, 1'b1);
    repeat (20) @(negedge clk);
    check("rdy_after_a5", {31'd0, bus.resp_rdy}, 1);
    bus.clr_resp_rdy = 1'b1;
    @(negedge clk);
    bus.clr_resp_rdy = 1'b0;
    check("rdy_after_clr", {31'd0, bus.resp_rdy}, 0);
    check("resp_after_clr", {24'd0, bus.resp}, 32'hA5);
    rx_frame(8'h5A, 1'b0);
    repeat (40) @(negedge clk);
    check("rdy_after_frame_err", {31'd0, bus.resp_rdy}, 0);
    check("resp_after_frame_err", {24'd0, bus.resp}, 32'hA5);
    bus.RX = 1'b0;
    repeat (4) @(negedge clk);
    bus.RX = 1'b1;
    repeat (200) @(negedge clk);
    check("rdy_after_glitch", {31'd0, bus.resp_rdy}, 0);
    check("resp_after_glitch", {24'd0, bus.resp}, 32'hA5);
    rx_frame(8'h3C, 1'b1);
    repeat (20) @(negedge clk);
    rx_frame(8'hC3, 1'b1);
    void'(exp_rx.pop_back());
    repeat (20) @(negedge clk);
    check("resp_overwrite", {24'd0, bus.resp}, 32'hC3);
    check("rdy_overwrite", {31'd0, bus.resp_rdy}, 1);
    fork
      send_cmd(16'h1234);
      begin
        repeat (5) @(negedge clk);
        rx_frame(8'h5A, 1'b1);
      end
    join
    wait_snt_drained();
    check("duplex_resp", {24'd0, bus.resp}, 32'h5A);
    check("duplex_rdy", {31'd0, bus.resp_rdy}, 1);
`ifdef REMOTE_COMM_TIMEOUT_EN
    send_cmd(16'h0102);
    check("resp_to_idle", {31'd0, bus.resp_to}, 0);
    for (int i = 0; i < 20 * B + 50 && bus.cmd_snt !== 1'b1; i++) @(negedge clk);
    k = cyc;
    for (int i = 0; i < 2100 && bus.resp_to !== 1'b1; i++) @(negedge clk);
    check("resp_to_latency", cyc - k, 2000);
    send_cmd(16'h0304);
    check("resp_to_cleared", {31'd0, bus.resp_to}, 0);
    for (int i = 0; i < 20 * B + 50 && bus.cmd_snt !== 1'b1; i++) @(negedge clk);
    repeat (500) @(negedge clk);
    rx_frame(8'hA5, 1'b1);
    n_tx = 0;
    for (int i = 0; i < 2100; i++) begin
      @(negedge clk);
      n_tx += int'(bus.resp_to !== 1'b0);
    end
    check("resp_to_with_response", n_tx, 0);
`endif
    send_cmd(16'h0000);
    repeat (40) @(negedge clk);
    rst_gen++;
    exp_tx.delete();
    exp_snt.delete();
    #2 rst_n = 1'b0;
    #1;
    check("reset_tx_high", {31'd0, bus.TX}, 1);
    check("reset_busy", {31'd0, bus.busy}, 0);
    check("reset_resp_rdy", {31'd0, bus.resp_rdy}, 0);
    check("reset_resp", {24'd0, bus.resp}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n_tx = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_tx += int'(bus.TX !== 1'b1 || bus.busy !== 1'b0 || bus.cmd_snt !== 1'b0);
    end
    check("post_reset_idle", n_tx, 0);
    check("exp_tx_drained", exp_tx.size(), 0);
    check("exp_rx_drained", exp_rx.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/remote_comm.md
Name: remote_comm

Overview:
- Bench-side/host-side Bluetooth command source that sits directly upstream of the Knight's Tour top level.
- Serialises a 16-bit command as two 8N1 UART bytes on TX (high byte first), which drive the robot's RX input.
- Receives the robot's single-byte response (0xA5 done / 0x5A in progress) on RX, which is driven by the robot's TX.
- Contains its own transmit and receive UART engines; no external UART block is used.

Parameters:
- BAUD_DIV, 5208: clock cycles per bit (50 MHz / 9600 baud); legal range 8..65535.
- TO_CYCLES, 25000000: response timeout in clocks. Used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- snd_cmd  in  1  one-clock strobe: start sending cmd
- cmd  in  16  command word; sampled on the snd_cmd cycle
- cmd_snt  out  1  one-clock pulse when both bytes have been transmitted
- TX  out  1  serial out to robot RX; idle high
- RX  in  1  serial in from robot TX; asynchronous
- clr_resp_rdy  in  1  clears resp_rdy
- resp_rdy  out  1  response byte valid (level)
- resp  out  8  last received response byte
- busy  out  1  transmit sequence in progress

Behaviour:
- Reset values: TX=1, cmd_snt=0, resp_rdy=0, resp=8'h00, busy=0. All state machines return to IDLE; any frame in flight is abandoned. TX returns high immediately on assertion of rst_n low.

Transmit FSM (states IDLE, HIGH, LOW, DONE):
- IDLE: snd_cmd=1 latches cmd into a 16-bit holding register, sets busy=1 and enters HIGH.
- snd_cmd while busy=1 is ignored; the holding register is not altered.
- HIGH: sends frame of cmd[15:8]; on stop-bit completion goes to LOW.
- LOW: sends frame of cmd[7:0] with no idle gap after the HIGH frame; on stop-bit completion goes to DONE.
- DONE: lasts exactly one cycle; cmd_snt=1, busy=0, then IDLE.
- A new snd_cmd may be accepted on the cycle after DONE.
- Frame format: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts exactly BAUD_DIV clocks, so one frame is 10*BAUD_DIV clocks.
- Latency: first TX falling edge occurs on the cycle after snd_cmd. cmd_snt pulses 20*BAUD_DIV+1 cycles after snd_cmd.
- Baud counter is 16 bits and reloads on every bit boundary. Bit counter counts 0..9.

Receive FSM (states IDLE, RECV):
- RX passes through a 2-flop synchroniser, reset value 1 (prevents a false start bit out of reset).
- IDLE: a synchronised falling edge enters RECV. The first sample is taken BAUD_DIV/2 clocks later (integer divide); subsequent samples every BAUD_DIV clocks; 10 samples total.
- Start sample = 1: treated as a glitch, return to IDLE and discard.
- Stop sample = 0: framing error, discard the byte; resp and resp_rdy are unchanged.
- Valid frame: resp is loaded and resp_rdy is set on the cycle after the stop sample.
- resp_rdy clears on clr_resp_rdy or on an accepted snd_cmd.
- If a set (valid frame) and a clear occur in the same cycle, set wins.
- A new valid byte overwrites resp even when resp_rdy is already 1.
- Receiver runs independently of transmit; full duplex is supported.

Optional Feature:
- Macro: REMOTE_COMM_TIMEOUT_EN
- Compiled in:
  - Adds output resp_to (1 bit, reset 0) and a 25-bit counter.
  - Counter clears and arms on the cmd_snt pulse; disarms when a valid response frame completes.
  - If it reaches TO_CYCLES-1 while armed, resp_to is set and the counter disarms.
  - resp_to clears on the next accepted snd_cmd or on clr_resp_rdy.
- Compiled out: no resp_to port, no counter, and no behavioural change elsewhere.

Test Plan (BAUD_DIV=16, TO_CYCLES=2000):
- Reset, no stimulus -> TX=1, busy=0, resp_rdy=0, resp=0x00 for 1000 cycles.
- snd_cmd with cmd=16'h2A51 -> TX emits 0x2A then 0x51 frames, each bit 16 clocks; cmd_snt pulses at cycle 321; busy low from that cycle.
- Second snd_cmd (cmd=16'hFFFF) at cycle 50 of a send -> ignored; the transmitted bytes remain 0x2A, 0x51.
- Bench drives 0xA5 on RX at 16 clocks/bit -> resp=0xA5 and resp_rdy=1 one cycle after the stop sample; clr_resp_rdy -> resp_rdy=0 and resp stays 0xA5.
- RX frame 0x5A with stop bit forced 0 -> resp_rdy stays 0 and resp is unchanged. A 4-clock low glitch on RX -> no byte is received.
- REMOTE_COMM_TIMEOUT_EN: send a command with no response -> resp_to=1 at 2000 cycles after cmd_snt. Repeat with 0xA5 returned at cycle 500 -> resp_to stays 0. Reset mid-frame -> TX=1 immediately and the FSMs are in IDLE.
